// File: rtl/grid_arbiter_if.sv
// rtl/grid_arbiter_if.sv - requester-side handshake bundle for grid_arbiter
interface grid_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]        req;
  logic [2*NREQ-1:0]      op;
  logic [32*NREQ-1:0]     addr;
  logic [DATA_W*NREQ-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic [DATA_W-1:0]      rdata;
  logic                   ok;
  logic                   busy;

  // Requesters drive the request side and observe grants/completions
  modport master (
    output req, op, addr, wdata,
    input  gnt, done, rdata, ok, busy
  );

  // The arbiter consumes requests and returns grants/completions
  modport slave (
    input  req, op, addr, wdata,
    output gnt, done, rdata, ok, busy
  );
endinterface

// File: rtl/grid_arbiter.sv
// rtl/grid_arbiter.sv - round-robin arbiter giving placement engines atomic grid RAM access
module grid_arbiter #(
  parameter int NREQ       = 4,
  parameter int DATA_W     = 32,
  parameter int GRID_CELLS = 49,
  parameter int EMPTY      = -1
) (
  input  logic              clk,
  input  logic              reset,
  grid_arbiter_if.slave     bus,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [DATA_W-1:0] EMPTY_W = DATA_W'(EMPTY);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLAIM = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    RD_WAIT,
    CLAIM_WR,
    RESP
  } state_t;

  state_t              state;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    cur_k;
  logic [1:0]          cur_op;
  logic [31:0]         cur_addr;
  logic [DATA_W-1:0]   cur_wdata;

  logic                found;
  logic [PTR_W-1:0]    pick;
  logic [PTR_W-1:0]    pick_next;
  logic [1:0]          sel_op;
  logic [31:0]         sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_bad;
  int                  idx;

  // Round-robin search starting at ptr; picks the first requester with req high
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx[PTR_W-1:0];
      end
    end
  end

  // Fields of the winning requester and the pointer value that follows it
  always_comb begin
    pick_next = (int'(pick) == NREQ - 1) ? '0 : pick + 1'b1;
    sel_op    = bus.op[int'(pick)*2 +: 2];
    sel_addr  = bus.addr[int'(pick)*32 +: 32];
    sel_wdata = bus.wdata[int'(pick)*DATA_W +: DATA_W];
    sel_bad   = (sel_addr >= 32'(GRID_CELLS)) || (sel_op == OP_RSVD);
  end

  // Transaction FSM; memory strobes are launched one state early so that they
  // are high during ISSUE/CLAIM_WR, and the RAM answer lands during RD_WAIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cur_k     <= '0;
      cur_op    <= OP_READ;
      cur_addr  <= '0;
      cur_wdata <= '0;
      bus.gnt   <= '0;
      bus.done  <= '0;
      bus.rdata <= '0;
      bus.ok    <= 1'b0;
      bus.busy  <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
    end else begin
      bus.gnt   <= '0;
      bus.done  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            bus.gnt[pick] <= 1'b1;
            cur_k         <= pick;
            cur_op        <= sel_op;
            cur_addr      <= sel_addr;
            cur_wdata     <= sel_wdata;
            ptr           <= pick_next;
            bus.busy      <= 1'b1;
            if (sel_bad) begin
              // Out-of-range address or reserved opcode never touches the RAM
              state  <= RESP;
              bus.ok <= 1'b0;
            end else begin
              state    <= ISSUE;
              mem_addr <= sel_addr;
              mem_din  <= sel_wdata;
              if (sel_op == OP_WRITE) begin
                mem_write <= 1'b1;
              end else begin
                mem_read <= 1'b1;
              end
            end
          end
        end
        ISSUE: begin
          if (cur_op == OP_WRITE) begin
            state  <= RESP;
            bus.ok <= 1'b1;
          end else begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          bus.rdata <= mem_dout;
          if (cur_op == OP_CLAIM && mem_dout == EMPTY_W) begin
            // Write follows the read directly, so no other access can slip in
            state     <= CLAIM_WR;
            mem_write <= 1'b1;
            mem_addr  <= cur_addr;
            mem_din   <= cur_wdata;
          end else begin
            state  <= RESP;
            bus.ok <= (cur_op == OP_READ);
          end
        end
        CLAIM_WR: begin
          state  <= RESP;
          bus.ok <= 1'b1;
        end
        RESP: begin
          bus.done[cur_k] <= 1'b1;
          bus.busy        <= 1'b0;
          state           <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_arbiter.sv
// tb/tb_grid_arbiter.sv - directed self-checking bench for grid_arbiter
module tb_grid_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  grid_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

  grid_arbiter #(
    .NREQ(NREQ), .DATA_W(DATA_W), .GRID_CELLS(49), .EMPTY(-1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grid RAM model: synchronous write, read data valid the cycle after mem_read
  logic [DATA_W-1:0] ram [0:63];
  logic              ram_clear;
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 64; i++) ram[i] <= '1;
    end else begin
      if (mem_write) ram[mem_addr[5:0]] <= mem_din;
      if (mem_read)  mem_dout <= ram[mem_addr[5:0]];
    end
  end

  int mw_cnt = 0;
  int mr_cnt = 0;
  int done_cnt = 0;
  int gq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Protocol invariants and event logging, sampled mid-cycle
  always @(negedge clk) begin
    chk("gnt_onehot0", 64'($onehot0(bus.gnt)), 64'd1);
    chk("done_onehot0", 64'($onehot0(bus.done)), 64'd1);
    chk("rd_wr_excl", 64'(mem_read & mem_write), 64'd0);
    if (mem_write) mw_cnt++;
    if (mem_read) mr_cnt++;
    if (bus.done != '0) done_cnt++;
    if (bus.gnt != '0) gq.push_back($clog2(bus.gnt));
  end

  // One transaction for requester k; returns grant-to-done latency and response
  task automatic run(input string tag, input int k, input logic [1:0] o,
                     input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] rd, output logic okv);
    int n;
    int g;
    n = 0;
    g = -100;
    @(negedge clk);
    bus.req[k] = 1'b1;
    bus.op[k*2 +: 2] = o;
    bus.addr[k*32 +: 32] = a;
    bus.wdata[k*32 +: 32] = d;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (bus.gnt[k]) g = n;
      if (bus.done[k]) break;
    end
    chk({tag, "_done_seen"}, 64'(bus.done[k]), 64'd1);
    lat = n - g;
    rd  = bus.rdata;
    okv = bus.ok;
    bus.req[k] = 1'b0;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        okv;
  int          mw0;
  int          mr0;
  int          d0;
  int          n;

  initial begin
    reset     = 1'b0;
    ram_clear = 1'b1;
    bus.req   = '0;
    bus.op    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    ram_clear = 1'b0;

    // Reset values
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_ok", 64'(bus.ok), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    chk("rst_mem_strobes", 64'({mem_read, mem_write}), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_din", 64'(mem_din), 64'd0);
    reset = 1'b1;

    // Write then read back through another requester
    run("wr_k0", 0, 2'b01, 32'd10, 32'd5, lat, rd, okv);
    chk("wr_k0_lat", 64'(lat), 64'd2);
    chk("wr_k0_ok", 64'(okv), 64'd1);
    chk("wr_k0_ram", 64'(ram[10]), 64'd5);
    run("rd_k1", 1, 2'b00, 32'd10, 32'd0, lat, rd, okv);
    chk("rd_k1_lat", 64'(lat), 64'd3);
    chk("rd_k1_rdata", 64'(rd), 64'd5);
    chk("rd_k1_ok", 64'(okv), 64'd1);

    // Claim on empty cell succeeds, second claim on same cell fails
    run("cl_k2", 2, 2'b10, 32'd3, 32'h22, lat, rd, okv);
    chk("cl_k2_lat", 64'(lat), 64'd4);
    chk("cl_k2_ok", 64'(okv), 64'd1);
    chk("cl_k2_ram", 64'(ram[3]), 64'h22);
    mw0 = mw_cnt;
    run("cl_k3", 3, 2'b10, 32'd3, 32'h33, lat, rd, okv);
    chk("cl_k3_lat", 64'(lat), 64'd3);
    chk("cl_k3_ok", 64'(okv), 64'd0);
    chk("cl_k3_rdata", 64'(rd), 64'h22);
    chk("cl_k3_no_write", 64'(mw_cnt - mw0), 64'd0);
    chk("cl_k3_ram", 64'(ram[3]), 64'h22);

    // Rejected requests: address out of range, reserved opcode
    mw0 = mw_cnt;
    mr0 = mr_cnt;
    run("bad_addr", 0, 2'b10, 32'd49, 32'h44, lat, rd, okv);
    chk("bad_addr_lat", 64'(lat), 64'd1);
    chk("bad_addr_ok", 64'(okv), 64'd0);
    run("bad_op", 1, 2'b11, 32'd5, 32'h55, lat, rd, okv);
    chk("bad_op_lat", 64'(lat), 64'd1);
    chk("bad_op_ok", 64'(okv), 64'd0);
    chk("bad_no_mem", 64'((mw_cnt - mw0) + (mr_cnt - mr0)), 64'd0);
    chk("bad_ram5", 64'(ram[5]), 64'hffff_ffff);

    // All four requesting from reset: grants 0,1,2,3,0 and first grant right after release
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      bus.op[i*2 +: 2] = 2'b00;
      bus.addr[i*32 +: 32] = 32'(i);
    end
    bus.req = '1;
    @(negedge clk);
    gq.delete();
    reset = 1'b1;
    @(negedge clk);
    chk("rr_first_gnt", 64'(bus.gnt), 64'd1);
    n = 0;
    while (gq.size() < 5 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("rr_count", 64'(gq.size() >= 5), 64'd1);
    if (gq.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", 64'(gq[i]), 64'(i % 4));
    end
    bus.req = '0;
    n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rr_idle", 64'(bus.busy), 64'd0);

    // Reset in CLAIM_WR aborts cleanly; cell stays empty and re-claim succeeds
    @(negedge clk);
    bus.op[2 +: 2] = 2'b10;
    bus.addr[32 +: 32] = 32'd7;
    bus.wdata[32 +: 32] = 32'h77;
    bus.req[1] = 1'b1;
    n = 0;
    while (!bus.gnt[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_gnt", 64'(bus.gnt[1]), 64'd1);
    repeat (2) @(negedge clk);
    chk("abort_in_claim_wr", 64'(mem_write), 64'd1);
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    chk("abort_mem_write", 64'(mem_write), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    bus.req[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_ram7", 64'(ram[7]), 64'hffff_ffff);
    reset = 1'b1;
    run("reclaim", 1, 2'b10, 32'd7, 32'h77, lat, rd, okv);
    chk("reclaim_lat", 64'(lat), 64'd4);
    chk("reclaim_ok", 64'(okv), 64'd1);
    chk("reclaim_ram7", 64'(ram[7]), 64'h77);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
